// File: rtl/iob_fifo_sync_asym_ctrl_if.sv
// Producer/consumer handshake for the width-converting FIFO controller.
// The slave modport is the FIFO side; master is the producer/consumer side.
interface iob_fifo_sync_asym_ctrl_if #(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 10
);
  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                w_full;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                r_empty;
  logic [ADDR_W:0]     level;
  logic                overflow;
  logic                underflow;

  modport slave (
    input  w_en, w_data, r_en,
    output w_full, r_data, r_empty, level, overflow, underflow
  );

  modport master (
    output w_en, w_data, r_en,
    input  w_full, r_data, r_empty, level, overflow, underflow
  );
endinterface

// File: rtl/iob_fifo_sync_asym_ctrl.sv
// Sequences an external iob_ram_2p_asym as a width-converting FIFO:
// pointers, occupancy in min-width units, full/empty and sticky error flags.
module iob_fifo_sync_asym_ctrl #(
  parameter  int W_DATA_W  = 32,
  parameter  int R_DATA_W  = 8,
  parameter  int ADDR_W    = 10,
  localparam int MINDATA_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W,
  localparam int MAXDATA_W = (W_DATA_W < R_DATA_W) ? R_DATA_W : W_DATA_W,
  localparam int N         = MAXDATA_W / MINDATA_W,
  localparam int W_ADDR_W  = (W_DATA_W == MINDATA_W) ? ADDR_W : ADDR_W - $clog2(N),
  localparam int R_ADDR_W  = (R_DATA_W == MINDATA_W) ? ADDR_W : ADDR_W - $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  iob_fifo_sync_asym_ctrl_if.slave fifo,
  output logic                 mem_w_en,
  output logic [W_ADDR_W-1:0]  mem_w_addr,
  output logic [W_DATA_W-1:0]  mem_w_data,
  output logic                 mem_r_en,
  output logic [R_ADDR_W-1:0]  mem_r_addr,
  input  logic [R_DATA_W-1:0]  mem_r_data
);

  localparam int WR  = W_DATA_W / MINDATA_W;
  localparam int RR  = R_DATA_W / MINDATA_W;
  localparam int CAP = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] WR_L     = (ADDR_W+1)'(WR);
  localparam logic [ADDR_W:0] RR_L     = (ADDR_W+1)'(RR);
  localparam logic [ADDR_W:0] FULL_THR = (ADDR_W+1)'(CAP - WR);

  logic [W_ADDR_W-1:0] w_ptr;
  logic [R_ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]     level;
  logic [ADDR_W:0]     level_nxt;
  logic                overflow;
  logic                underflow;
  logic                w_full;
  logic                r_empty;
  logic                wacc;
  logic                racc;

  // Flags decode straight from the level register, one cycle behind the edge.
  assign w_full  = level > FULL_THR;
  assign r_empty = level < RR_L;
  assign wacc    = fifo.w_en & ~w_full;
  assign racc    = fifo.r_en & ~r_empty;

  assign mem_w_en   = wacc;
  assign mem_w_addr = w_ptr;
  assign mem_w_data = fifo.w_data;
  assign mem_r_en   = racc;
  assign mem_r_addr = r_ptr;

  assign fifo.r_data    = mem_r_data;
  assign fifo.w_full    = w_full;
  assign fifo.r_empty   = r_empty;
  assign fifo.level     = level;
  assign fifo.overflow  = overflow;
  assign fifo.underflow = underflow;

  always_comb begin
    level_nxt = level;
    if (wacc) level_nxt = level_nxt + WR_L;
    if (racc) level_nxt = level_nxt - RR_L;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wacc) w_ptr <= w_ptr + W_ADDR_W'(1);
      if (racc) r_ptr <= r_ptr + R_ADDR_W'(1);
      level <= level_nxt;
      if (fifo.w_en & w_full)  overflow  <= 1'b1;
      if (fifo.r_en & r_empty) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iob_fifo_sync_asym_ctrl.sv
// Directed bench: a 32->8 FIFO and an 8->32 FIFO, each with an asymmetric RAM model.
module tb_iob_fifo_sync_asym_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  iob_fifo_sync_asym_ctrl_if #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) f0 ();
  iob_fifo_sync_asym_ctrl_if #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) f1 ();

  logic        mem_w_en0;
  logic [1:0]  mem_w_addr0;
  logic [31:0] mem_w_data0;
  logic        mem_r_en0;
  logic [3:0]  mem_r_addr0;
  logic [7:0]  mem_r_data0;

  logic        mem_w_en1;
  logic [3:0]  mem_w_addr1;
  logic [7:0]  mem_w_data1;
  logic        mem_r_en1;
  logic [1:0]  mem_r_addr1;
  logic [31:0] mem_r_data1;

  logic [7:0] ram0 [16];
  logic [7:0] ram1 [16];

  iob_fifo_sync_asym_ctrl #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .fifo       (f0),
    .mem_w_en   (mem_w_en0),
    .mem_w_addr (mem_w_addr0),
    .mem_w_data (mem_w_data0),
    .mem_r_en   (mem_r_en0),
    .mem_r_addr (mem_r_addr0),
    .mem_r_data (mem_r_data0)
  );

  iob_fifo_sync_asym_ctrl #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .fifo       (f1),
    .mem_w_en   (mem_w_en1),
    .mem_w_addr (mem_w_addr1),
    .mem_w_data (mem_w_data1),
    .mem_r_en   (mem_r_en1),
    .mem_r_addr (mem_r_addr1),
    .mem_r_data (mem_r_data1)
  );

  // Little-endian asymmetric RAM models with registered read.
  always_ff @(posedge clk) begin
    if (mem_w_en0)
      for (int k = 0; k < 4; k++) ram0[{mem_w_addr0, 2'(k)}] <= mem_w_data0[8*k +: 8];
    if (mem_r_en0) mem_r_data0 <= ram0[mem_r_addr0];
  end

  always_ff @(posedge clk) begin
    if (mem_w_en1) ram1[mem_w_addr1] <= mem_w_data1;
    if (mem_r_en1)
      mem_r_data1 <= {ram1[{mem_r_addr1, 2'd3}], ram1[{mem_r_addr1, 2'd2}],
                      ram1[{mem_r_addr1, 2'd1}], ram1[{mem_r_addr1, 2'd0}]};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] q0 [$];
  int         lvl0;
  int         wp0;
  int         rp0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q0.delete();
    lvl0 = 0;
    wp0  = 0;
    rp0  = 0;
  endtask

  // One cycle on the 32->8 FIFO where every request is expected to be accepted.
  task automatic op0(input logic we, input logic [31:0] wd, input logic re);
    logic [7:0] eb;
    eb = 8'h00;
    f0.w_en   = we;
    f0.w_data = wd;
    f0.r_en   = re;
    #1;
    chk("mem_w_en0", {31'd0, mem_w_en0}, {31'd0, we});
    chk("mem_r_en0", {31'd0, mem_r_en0}, {31'd0, re});
    if (we) begin
      chk("mem_w_addr0", {30'd0, mem_w_addr0}, wp0);
      chk("mem_w_data0", mem_w_data0, wd);
      wp0 = (wp0 + 1) % 4;
    end
    if (re) begin
      chk("mem_r_addr0", {28'd0, mem_r_addr0}, rp0);
      rp0 = (rp0 + 1) % 16;
      if (q0.size() > 0) eb = q0.pop_front();
    end
    if (we) for (int k = 0; k < 4; k++) q0.push_back(wd[8*k +: 8]);
    lvl0 = lvl0 + (we ? 4 : 0) - (re ? 1 : 0);
    @(negedge clk);
    f0.w_en = 1'b0;
    f0.r_en = 1'b0;
    chk("level0", {27'd0, f0.level}, lvl0);
    chk("r_empty0", {31'd0, f0.r_empty}, (lvl0 < 1) ? 1 : 0);
    chk("w_full0", {31'd0, f0.w_full}, (lvl0 > 12) ? 1 : 0);
    if (re) chk("r_data0", {24'd0, f0.r_data}, {24'd0, eb});
  endtask

  initial begin
    logic [7:0] wb [4];
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    f0.w_en = 1'b0; f0.w_data = '0; f0.r_en = 1'b0;
    f1.w_en = 1'b0; f1.w_data = '0; f1.r_en = 1'b0;
    @(negedge clk);
    do_rst();

    chk("rst_level0", {27'd0, f0.level}, 0);
    chk("rst_empty0", {31'd0, f0.r_empty}, 1);
    chk("rst_full0", {31'd0, f0.w_full}, 0);
    chk("rst_ovf0", {31'd0, f0.overflow}, 0);
    chk("rst_unf0", {31'd0, f0.underflow}, 0);

    // single write, byte-wise readout
    op0(1'b1, 32'h44332211, 1'b0);
    for (int i = 0; i < 4; i++) op0(1'b0, 32'h0, 1'b1);

    // fill to capacity, then one dropped write
    for (int i = 0; i < 4; i++) op0(1'b1, 32'h10 + i, 1'b0);
    f0.w_en = 1'b1; f0.w_data = 32'hFF;
    #1 chk("ovf_mem_w_en0", {31'd0, mem_w_en0}, 0);
    @(negedge clk);
    f0.w_en = 1'b0;
    chk("ovf_flag0", {31'd0, f0.overflow}, 1);
    chk("ovf_level0", {27'd0, f0.level}, 16);
    for (int i = 0; i < 16; i++) op0(1'b0, 32'h0, 1'b1);
    chk("ovf_sticky0", {31'd0, f0.overflow}, 1);

    // underflow after reset
    do_rst();
    chk("ovf_clr0", {31'd0, f0.overflow}, 0);
    f0.r_en = 1'b1;
    #1 chk("unf_mem_r_en0", {31'd0, mem_r_en0}, 0);
    @(negedge clk);
    f0.r_en = 1'b0;
    chk("unf_flag0", {31'd0, f0.underflow}, 1);
    chk("unf_level0", {27'd0, f0.level}, 0);
    repeat (3) @(negedge clk);
    chk("unf_sticky0", {31'd0, f0.underflow}, 1);
    do_rst();
    chk("unf_clr0", {31'd0, f0.underflow}, 0);

    // pointer wrap with simultaneous write/read cycles, level never above 7
    op0(1'b1, 32'h100, 1'b0);
    for (int i = 1; i < 10; i++) begin
      op0(1'b1, 32'h100 + i, 1'b1);
      for (int j = 0; j < 3; j++) op0(1'b0, 32'h0, 1'b1);
    end
    for (int i = 0; i < 4; i++) op0(1'b0, 32'h0, 1'b1);

    // reset mid-stream at level 9
    for (int i = 0; i < 3; i++) op0(1'b1, 32'hC0 + i, 1'b0);
    for (int i = 0; i < 3; i++) op0(1'b0, 32'h0, 1'b1);
    chk("pre_rst_level0", {27'd0, f0.level}, 9);
    do_rst();
    chk("mid_level0", {27'd0, f0.level}, 0);
    chk("mid_empty0", {31'd0, f0.r_empty}, 1);
    chk("mid_full0", {31'd0, f0.w_full}, 0);
    chk("mid_ovf0", {31'd0, f0.overflow}, 0);
    chk("mid_unf0", {31'd0, f0.underflow}, 0);
    op0(1'b1, 32'hA5A5A5A5, 1'b0);
    for (int i = 0; i < 4; i++) op0(1'b0, 32'h0, 1'b1);

    // 8 -> 32 instance
    wb[0] = 8'h11; wb[1] = 8'h22; wb[2] = 8'h33; wb[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      f1.w_en = 1'b1; f1.w_data = wb[i];
      #1 chk("n_mem_w_addr1", {28'd0, mem_w_addr1}, i);
      @(negedge clk);
      f1.w_en = 1'b0;
      chk("n_level1", {27'd0, f1.level}, i + 1);
      chk("n_empty1", {31'd0, f1.r_empty}, (i < 3) ? 1 : 0);
      chk("n_full1", {31'd0, f1.w_full}, 0);
    end
    f1.r_en = 1'b1;
    #1;
    chk("n_mem_r_en1", {31'd0, mem_r_en1}, 1);
    chk("n_mem_r_addr1", {30'd0, mem_r_addr1}, 0);
    @(negedge clk);
    f1.r_en = 1'b0;
    chk("n_r_data1", f1.r_data, 32'h44332211);
    chk("n_level1_end", {27'd0, f1.level}, 0);
    chk("n_empty1_end", {31'd0, f1.r_empty}, 1);
    chk("n_unf1", {31'd0, f1.underflow}, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
